llc_cmd_sequencer: RTL and testbench

Command sequencer directly upstream of the LLC model. It buffers trace commands (op code + 32-bit address) from the trace reader in a small FIFO and drives the LLC's `op`/`addr` inputs one command at a time. It samples the LLC's `hold` output after each issue and automatically re-issues the same command when the LLC evicted a victim or split a snoop write-back. Between commands it drives an idle op so the LLC never sees a command twice by accident.

---
 rtl/llc_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_llc_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/llc_cmd_sequencer.sv
// Command sequencer in front of the LLC model: buffers trace commands in a FIFO,
// issues them one at a time and re-issues a command when the LLC raises hold.
module llc_cmd_sequencer #(
   parameter int DEPTH     = 8,
   parameter int MAX_RETRY = 2,
   parameter int IDLE_OP   = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [31:0] cmd_op,
   input  logic [31:0] cmd_addr,
   output logic        cmd_ready,
   output logic [31:0] llc_op,
   output logic [31:0] llc_addr,
   input  logic        llc_hold,
   output logic        busy,
   output logic [31:0] issued_count,
   output logic [31:0] retry_count,
   output logic        retry_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
   // cmd_ready depends only on FIFO fullness, never on cmd_valid.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [31:0]   fifo_op   [DEPTH];
   logic [31:0]   fifo_addr [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          full, empty, push, pop;

   logic [31:0]   cur_op, cur_addr;
   logic [RW-1:0] retries;

   logic          load_new, reissue, drive_idle;
   logic          inc_issued, inc_retry, set_err;
   logic          retry_hit, can_retry, is_ctrl_op;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign busy      = !empty || (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr[AW-1:0]]   <= cmd_op;
         fifo_addr[wr_ptr[AW-1:0]] <= cmd_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Only demand reads, writes and snoop-rd-with-intent (op 5) can be split by the LLC.
   assign retry_hit  = llc_hold && ((cur_op == 32'd0) || (cur_op == 32'd1) ||
                                    (cur_op == 32'd2) || (cur_op == 32'd5));
   assign can_retry  = (retries < RW'(MAX_RETRY));
   assign is_ctrl_op = (cur_op == 32'd8) || (cur_op == 32'd9);

   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      load_new   = 1'b0;
      reissue    = 1'b0;
      drive_idle = 1'b0;
      inc_issued = 1'b0;
      inc_retry  = 1'b0;
      set_err    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               load_new  = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            drive_idle = 1'b1;
            if (is_ctrl_op) begin
               inc_issued = 1'b1;
               state_nxt  = S_IDLE;
            end else begin
               state_nxt  = S_CHECK;
            end
         end
         S_CHECK: begin
            if (retry_hit && can_retry) begin
               reissue   = 1'b1;
               inc_retry = 1'b1;
               state_nxt = S_ISSUE;
            end else begin
               inc_issued = 1'b1;
               set_err    = retry_hit;
               if (!empty) begin
                  pop       = 1'b1;
                  load_new  = 1'b1;
                  state_nxt = S_ISSUE;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // llc_op carries a real command for exactly the one ISSUE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         llc_op   <= 32'(IDLE_OP);
         llc_addr <= '0;
         cur_op   <= '0;
         cur_addr <= '0;
         retries  <= '0;
      end else if (load_new) begin
         llc_op   <= fifo_op[rd_ptr[AW-1:0]];
         llc_addr <= fifo_addr[rd_ptr[AW-1:0]];
         cur_op   <= fifo_op[rd_ptr[AW-1:0]];
         cur_addr <= fifo_addr[rd_ptr[AW-1:0]];
         retries  <= '0;
      end else if (reissue) begin
         llc_op   <= cur_op;
         llc_addr <= cur_addr;
         retries  <= retries + RW'(1);
      end else if (drive_idle) begin
         llc_op   <= 32'(IDLE_OP);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_count <= '0;
         retry_count  <= '0;
         retry_err    <= 1'b0;
      end else begin
         if (inc_issued) issued_count <= issued_count + 32'd1;
         if (inc_retry)  retry_count  <= retry_count + 32'd1;
         if (set_err)    retry_err    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_llc_cmd_sequencer.sv
// Bench for llc_cmd_sequencer: commands pushed through a driver task, every LLC issue
// checked against an expected queue filled when the command is driven.
module tb_llc_cmd_sequencer;

   localparam int DEPTH     = 8;
   localparam int MAX_RETRY = 2;
   localparam int IDLE_OP   = 7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [31:0] cmd_op = '0;
   logic [31:0] cmd_addr = '0;
   logic        cmd_ready;
   logic [31:0] llc_op, llc_addr;
   logic        llc_hold = 1'b0;
   logic        busy;
   logic [31:0] issued_count, retry_count;
   logic        retry_err;

   llc_cmd_sequencer #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .IDLE_OP(IDLE_OP)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_ready(cmd_ready), .llc_op(llc_op), .llc_addr(llc_addr), .llc_hold(llc_hold),
      .busy(busy), .issued_count(issued_count), .retry_count(retry_count), .retry_err(retry_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int obs = 0;
   int acc = 0;
   int acc_cyc = 0;
   int pops = 0;
   int last_cyc = -1;
   bit lat_on = 0, gap_on = 0, stream_on = 0, saw_full = 0;
   logic [63:0] exp_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // scoreboard: every non-idle cycle on llc_op is one issue
   always @(posedge clk) begin
      logic [63:0] item;
      #2;
      if (rst_n && llc_op != 32'(IDLE_OP)) begin
         obs++;
         item = (exp_q.size() > 0) ? exp_q.pop_front() : {32'(IDLE_OP), 32'h0};
         check("issue", {llc_op, llc_addr}, item);
         if (lat_on) begin
            check("latency", 64'(cyc - acc_cyc), 64'd1);
            lat_on = 0;
         end
         if (gap_on && last_cyc >= 0) check("gap", 64'(cyc - last_cyc), 64'd2);
         last_cyc = cyc;
         if (stream_on) pops++;
      end
      if (stream_on && !cmd_ready) begin
         saw_full = 1;
         check("full_occupancy", 64'(acc - pops), 64'(DEPTH));
      end
   end

   // driver tasks
   task automatic push(input int op, input logic [31:0] addr, input int n_issue);
      int t = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      while (!cmd_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check("push_timeout", 64'(t), 64'd0);
      for (int i = 0; i < n_issue; i++) exp_q.push_back({32'(op), addr});
      @(posedge clk);
      #1;
      acc++;
      acc_cyc = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_issues(input int target);
      int t = 0;
      while (obs < target && t < 200) begin
         @(posedge clk);
         #3;
         t++;
      end
      if (t >= 200) check("wait_issue_timeout", 64'(obs), 64'(target));
   endtask

   task automatic wait_idle();
      int t = 0;
      @(posedge clk);
      #3;
      while (busy && t < 300) begin
         @(posedge clk);
         #3;
         t++;
      end
      if (t >= 300) check("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_llc_op", 64'(llc_op), 64'(IDLE_OP));
      check("rst_llc_addr", 64'(llc_addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ready", 64'(cmd_ready), 64'd1);
      check("rst_issued", 64'(issued_count), 64'd0);
      check("rst_retry", 64'(retry_count), 64'd0);
      check("rst_err", 64'(retry_err), 64'd0);
   endtask

   initial begin
      int base;

      // single read, no hold
      do_reset();
      llc_hold = 1'b0;
      base = obs;
      lat_on = 1;
      push(0, 32'h0000_1000, 1);
      wait_issues(base + 1);
      @(posedge clk); #3;
      check("t1_idle_op", 64'(llc_op), 64'(IDLE_OP));
      @(posedge clk); #3;
      check("t1_issued", 64'(issued_count), 64'd1);
      check("t1_retry", 64'(retry_count), 64'd0);
      check("t1_busy", 64'(busy), 64'd0);

      // write with one hold
      do_reset();
      llc_hold = 1'b1;
      base = obs;
      gap_on = 1;
      last_cyc = -1;
      push(1, 32'h8000_0040, 2);
      wait_issues(base + 2);
      llc_hold = 1'b0;
      wait_idle();
      gap_on = 0;
      check("t2_retry", 64'(retry_count), 64'd1);
      check("t2_issued", 64'(issued_count), 64'd1);
      check("t2_err", 64'(retry_err), 64'd0);

      // op 5 with hold stuck: abandoned after MAX_RETRY, next command still issues
      do_reset();
      llc_hold = 1'b1;
      push(5, 32'h0000_2000, 1 + MAX_RETRY);
      push(3, 32'h0000_3000, 1);
      wait_idle();
      check("t3_err", 64'(retry_err), 64'd1);
      check("t3_retry", 64'(retry_count), 64'(MAX_RETRY));
      check("t3_issued", 64'(issued_count), 64'd2);
      check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

      // snoops 3 and 6 never retry
      do_reset();
      llc_hold = 1'b1;
      push(3, 32'h0000_4000, 1);
      push(6, 32'h0000_5000, 1);
      wait_idle();
      check("t4_retry", 64'(retry_count), 64'd0);
      check("t4_issued", 64'(issued_count), 64'd2);
      check("t4_err", 64'(retry_err), 64'd0);
      llc_hold = 1'b0;

      // back-to-back stream until the FIFO fills
      do_reset();
      acc = 0;
      pops = 0;
      saw_full = 0;
      last_cyc = -1;
      gap_on = 1;
      stream_on = 1;
      for (int i = 0; i < 18; i++) begin
         int op;
         op = (i == 5) ? 8 : (i == 11) ? 9 : (i % 7);
         push(op, $urandom, 1);
      end
      wait_idle();
      stream_on = 0;
      gap_on = 0;
      check("t5_saw_full", 64'(saw_full), 64'd1);
      check("t5_issued", 64'(issued_count), 64'd18);
      check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

      // reset during ISSUE of op 2 with 3 commands queued
      do_reset();
      llc_hold = 1'b1;
      base = obs;
      push(5, 32'h0000_6000, 1 + MAX_RETRY);
      push(2, 32'h0000_7000, 1);
      push(0, 32'h0000_7100, 0);
      push(1, 32'h0000_7200, 0);
      push(4, 32'h0000_7300, 0);
      wait_issues(base + 2 + MAX_RETRY);
      check("t6_op2_live", 64'(llc_op), 64'd2);
      rst_n = 1'b0;
      exp_q.delete();
      llc_hold = 1'b0;
      #1;
      check("t6_async_op", 64'(llc_op), 64'(IDLE_OP));
      check("t6_ready", 64'(cmd_ready), 64'd1);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_issued", 64'(issued_count), 64'd0);
      check("t6_err", 64'(retry_err), 64'd0);
      base = obs;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("t6_no_issue", 64'(obs), 64'(base));
      check("t6_issued_after", 64'(issued_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
